// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, FSM states and grantee encoding for mem_arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package cpu_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {GNT_FETCH = 1'b0, GNT_DATA = 1'b1} gnt_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational grant select; with MEM_ARB_RR_EN a last-grant flop
// turns simultaneous requests into round-robin, otherwise data beats fetch.
module arb_pick
    import cpu_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic take,
    input  logic f_req,
`endif
    input  logic d_req,
    output logic gnt
);
`ifdef MEM_ARB_RR_EN
    logic last;
    always_ff @(posedge clk or posedge rst)
        if (rst) last <= GNT_FETCH;
        else if (take) last <= gnt;
    assign gnt = (f_req && d_req) ? ~last : d_req;
`else
    assign gnt = d_req;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store requesters.
// Arbitration is fixed data-first unless MEM_ARB_RR_EN is defined.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              busy
);
    state_t state, nxt;
    logic [2:0] cnt;
    logic gnt, gsel, wr, take, last_cyc;
    assign take = state == IDLE && (f_req || d_req);
    assign last_cyc = state == ACCESS && cnt == 3'd1;
    arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk(clk), .rst(rst), .take(take), .f_req(f_req),
`endif
        .d_req(d_req), .gnt(gsel)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb
        nxt = take ? ACCESS : last_cyc ? RESP : state == RESP ? IDLE : state;
    // counter counts the cycles left in ACCESS; the read byte is taken in its last one
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            f_ack <= 1'b0;
            f_rdata <= '0;
            d_ack <= 1'b0;
            d_rdata <= '0;
            mem_addr <= '0;
            mem_data_out <= '0;
            mem_we <= 1'b0;
            busy <= 1'b0;
            cnt <= '0;
            gnt <= GNT_FETCH;
            wr <= 1'b0;
        end else begin
            mem_we <= take && gsel && d_we;
            f_ack <= last_cyc && gnt == GNT_FETCH;
            d_ack <= last_cyc && gnt == GNT_DATA;
            busy <= nxt != IDLE;
            if (take) begin
                gnt <= gsel;
                wr <= gsel && d_we;
                mem_addr <= gsel ? d_addr : f_addr;
                if (gsel) mem_data_out <= d_wdata;
                cnt <= (gsel && d_we) ? 3'd1 : 3'(RD_LAT);
            end else if (state == ACCESS) cnt <= cnt - 3'd1;
            if (last_cyc && !wr && gnt == GNT_DATA) d_rdata <= mem_data_in;
            if (last_cyc && !wr && gnt == GNT_FETCH) f_rdata <= mem_data_in;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed steps with an ack scoreboard for RD_LAT=1 and RD_LAT=3 instances.
module tb_mem_arbiter;
    logic clk = 0, rst = 1;
    logic f_req = 0, d_req = 0, d_we = 0;
    logic [7:0] f_addr = 0, d_addr = 0, d_wdata = 0, mem_data_in = 0;
    logic f_ack1, d_ack1, mem_we1, busy1, f_ack3, d_ack3, mem_we3, busy3;
    logic [7:0] f_rdata1, d_rdata1, mem_addr1, mem_data_out1;
    logic [7:0] f_rdata3, d_rdata3, mem_addr3, mem_data_out3;
    int passed = 0, total = 0, fails = 0;
    typedef struct {logic is_d; logic [7:0] data; int lat;} exp_t;
    exp_t sb[$];
    logic [7:0] d_model = 0;
    logic first_d;

    always #5 clk = ~clk;

    mem_arbiter #(.RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack1), .f_rdata(f_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack1),
        .d_rdata(d_rdata1), .mem_addr(mem_addr1), .mem_data_out(mem_data_out1), .mem_we(mem_we1),
        .mem_data_in(mem_data_in), .busy(busy1));
    mem_arbiter #(.RD_LAT(3)) u3 (
        .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack3), .f_rdata(f_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack3),
        .d_rdata(d_rdata3), .mem_addr(mem_addr3), .mem_data_out(mem_data_out3), .mem_we(mem_we3),
        .mem_data_in(mem_data_in), .busy(busy3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [7:0] data, input int lat);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_ack1(input string tag, input int bound);
        exp_t e;
        bit seen = 0;
        e = sb.pop_front();
        for (int k = 1; k <= bound && !seen; k++) begin
            @(negedge clk);
            if (f_ack1 || d_ack1) begin
                seen = 1;
                check({tag, "_who"}, {f_ack1, d_ack1}, e.is_d ? 2'b01 : 2'b10);
                check({tag, "_lat"}, k, e.lat);
                check({tag, "_data"}, e.is_d ? d_rdata1 : f_rdata1, e.data);
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        check("rst_out1", {f_ack1, f_rdata1, d_ack1, d_rdata1, mem_addr1, mem_data_out1, mem_we1, busy1}, 0);
        check("rst_out3", {f_ack3, f_rdata3, d_ack3, d_rdata3, mem_addr3, mem_data_out3, mem_we3, busy3}, 0);
        rst = 0;
        f_req = 1; f_addr = 8'h10; mem_data_in = 8'hA5;
        push(0, 8'hA5, 1);
        @(negedge clk);
        check("fetch_addr", mem_addr1, 8'h10);
        check("fetch_busy", busy1, 1);
        wait_ack1("fetch", 8);
        f_req = 0;
        idle(1);
        d_req = 1; d_we = 0; d_addr = 8'h20; mem_data_in = 8'h5A;
        push(1, 8'h5A, 2);
        wait_ack1("load", 8);
        d_req = 0; d_model = 8'h5A;
        idle(1);
        d_req = 1; d_we = 1; d_addr = 8'h80; d_wdata = 8'h3C; mem_data_in = 8'hEE;
        push(1, d_model, 1);
        @(negedge clk);
        check("st_we", mem_we1, 1);
        check("st_addr", mem_addr1, 8'h80);
        check("st_wdata", mem_data_out1, 8'h3C);
        wait_ack1("store", 8);
        check("st_we_off", mem_we1, 0);
        d_req = 0; d_we = 0;
        idle(1);
`ifdef MEM_ARB_RR_EN
        first_d = 0;
`else
        first_d = 1;
`endif
        f_req = 1; f_addr = 8'h30; d_req = 1; d_addr = 8'h31; mem_data_in = 8'h11;
        push(first_d, 8'h11, 2);
        wait_ack1("cont_a", 8);
        if (first_d) d_req = 0; else f_req = 0;
        mem_data_in = 8'h22;
        push(!first_d, 8'h22, 3);
        wait_ack1("cont_b", 8);
        f_req = 0; d_req = 0;
        idle(1);
        f_req = 1; f_addr = 8'h40; mem_data_in = 8'h77;
        push(0, 8'h77, 1);
        @(negedge clk);
        f_req = 0;
        wait_ack1("drop", 8);
        idle(1);
        f_req = 1; f_addr = 8'h44; mem_data_in = 8'h99;
        push(0, 8'h99, 2);
        push(0, 8'h99, 3);
        wait_ack1("held_a", 8);
        wait_ack1("held_b", 8);
        f_req = 0;
        check("held_addr", mem_addr1, 8'h44);
        idle(1);
        d_req = 1; d_we = 1; d_addr = 8'h55; d_wdata = 8'h66;
        @(negedge clk);
        check("rmid_we_on", mem_we1, 1);
        #2 rst = 1;
        #1 check("rmid_we_off", mem_we1, 0);
        check("rmid_busy", busy1, 0);
        d_req = 0; d_we = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rmid_noack_rst", {f_ack1, d_ack1}, 0);
        end
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rmid_noack", {f_ack1, d_ack1, busy1}, 0);
        end
        f_req = 1; f_addr = 8'h12; mem_data_in = 8'hC3;
        push(0, 8'hC3, 2);
        wait_ack1("after_rst", 8);
        f_req = 0;
        rst = 1;
        idle(1);
        rst = 0;
        d_req = 1; d_we = 0; d_addr = 8'hFF; mem_data_in = 8'h40;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("lat_ack", d_ack3, k == 4);
            check("lat_busy", busy3, k <= 4);
            if (k <= 4) check("lat_addr", mem_addr3, 8'hFF);
            if (k == 4) begin
                check("lat_data", d_rdata3, 8'h43);
                d_req = 0;
            end
            mem_data_in = 8'h40 + 8'(k);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
